// File: rtl/sdhci_pkg.sv
// Shared SDHCI types: response type encodings and Response register width.
package sdhci_pkg;

  localparam int unsigned RSP_REG_W = 128;

  typedef enum logic [1:0] {
    NO_RESPONSE      = 2'd0,
    RESPONSE_136     = 2'd1,
    RESPONSE_48      = 2'd2,
    RESPONSE_48_BUSY = 2'd3
  } response_type_e;

  // Command register Response Type Select field encoding
  typedef enum logic [1:0] {
    RSP_SEL_NONE     = 2'b00,
    RSP_SEL_136      = 2'b01,
    RSP_SEL_48       = 2'b10,
    RSP_SEL_48_BUSY  = 2'b11
  } rsp_type_sel_e;

  function automatic response_type_e to_response_type(input rsp_type_sel_e sel);
    response_type_e rt;
    rt = NO_RESPONSE;
    case (sel)
      RSP_SEL_NONE:    rt = NO_RESPONSE;
      RSP_SEL_136:     rt = RESPONSE_136;
      RSP_SEL_48:      rt = RESPONSE_48;
      RSP_SEL_48_BUSY: rt = RESPONSE_48_BUSY;
      default:         rt = NO_RESPONSE;
    endcase
    return rt;
  endfunction

endpackage

// File: rtl/cmd_issue_ctrl.sv
// Command issue controller: launches commands to cmd_logic, tracks Command Inhibit,
// captures responses and pulses interrupt status bits. SDHCI_CMD_CHECK_EN gates CRC/index errors.
module cmd_issue_ctrl
  import sdhci_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sw_rst_cmd_i,
  input  logic                 cmd_reg_wr_i,
  input  logic [5:0]           cmd_index_i,
  input  logic [31:0]          cmd_arg_i,
  input  logic [1:0]           rsp_type_sel_i,
  input  logic                 crc_chk_en_i,
  input  logic                 idx_chk_en_i,
  output logic                 cmd_inhibit_o,
  output logic [5:0]           cmd_o,
  output logic [31:0]          cmd_arg_o,
  output response_type_e       response_type_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  input  logic                 cmd_done_i,
  input  logic                 cmd_result_valid_i,
  input  logic [119:0]         rsp_i,
  input  logic                 index_error_i,
  input  logic                 end_bit_error_i,
  input  logic                 crc_error_i,
  input  logic                 timeout_error_i,
  output logic [RSP_REG_W-1:0] rsp_reg_o,
  output logic                 cmd_complete_o,
  output logic                 cmd_timeout_err_o,
  output logic                 cmd_crc_err_o,
  output logic                 cmd_end_bit_err_o,
  output logic                 cmd_index_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, FINISH} state_e;

  state_e               state_q, state_d;
  logic [5:0]           cmd_d;
  logic [31:0]          arg_d;
  response_type_e       rtype_d;
  logic                 valid_d, inhibit_d;
  logic [RSP_REG_W-1:0] rsp_d;
  logic                 complete_d, timeout_d, crc_d, end_bit_d, index_d;
  logic                 crc_flag_c, idx_flag_c;

`ifdef SDHCI_CMD_CHECK_EN
  logic crc_en_q, crc_en_d, idx_en_q, idx_en_d;
  assign crc_flag_c = crc_error_i & crc_en_q;
  assign idx_flag_c = index_error_i & idx_en_q;
`else
  logic unused_chk_en;
  assign unused_chk_en = crc_chk_en_i ^ idx_chk_en_i;
  assign crc_flag_c    = crc_error_i;
  assign idx_flag_c    = index_error_i;
`endif

  // Next-state, latched payload and pulse generation
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_o;
    arg_d      = cmd_arg_o;
    rtype_d    = response_type_o;
    valid_d    = cmd_valid_o;
    inhibit_d  = cmd_inhibit_o;
    rsp_d      = rsp_reg_o;
    complete_d = 1'b0;
    timeout_d  = 1'b0;
    crc_d      = 1'b0;
    end_bit_d  = 1'b0;
    index_d    = 1'b0;
`ifdef SDHCI_CMD_CHECK_EN
    crc_en_d   = crc_en_q;
    idx_en_d   = idx_en_q;
`endif

    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (cmd_reg_wr_i) begin
          state_d   = ISSUE;
          cmd_d     = cmd_index_i;
          arg_d     = cmd_arg_i;
          rtype_d   = to_response_type(rsp_type_sel_e'(rsp_type_sel_i));
          valid_d   = 1'b1;
          inhibit_d = 1'b1;
`ifdef SDHCI_CMD_CHECK_EN
          crc_en_d  = crc_chk_en_i;
          idx_en_d  = idx_chk_en_i;
`endif
        end
      end
      ISSUE: begin
        if (cmd_valid_o && cmd_ready_i) begin
          state_d = WAIT_RES;
          valid_d = 1'b0;
        end
      end
      WAIT_RES: begin
        if (response_type_o == NO_RESPONSE) begin
          if (cmd_done_i) begin
            state_d    = FINISH;
            inhibit_d  = 1'b0;
            complete_d = 1'b1;
          end
        end else if (timeout_error_i) begin
          state_d   = FINISH;
          inhibit_d = 1'b0;
          timeout_d = 1'b1;
        end else if (cmd_result_valid_i) begin
          state_d    = FINISH;
          inhibit_d  = 1'b0;
          complete_d = 1'b1;
          crc_d      = crc_flag_c;
          end_bit_d  = end_bit_error_i;
          index_d    = idx_flag_c;
          if (response_type_o == RESPONSE_136) rsp_d = {8'h00, rsp_i};
          else                                 rsp_d[31:0] = rsp_i[31:0];
        end
      end
      default: state_d = IDLE;
    endcase

    // Software CMD reset clears everything except the Response register
    if (sw_rst_cmd_i) begin
      state_d    = IDLE;
      cmd_d      = 6'd0;
      arg_d      = 32'd0;
      rtype_d    = NO_RESPONSE;
      valid_d    = 1'b0;
      inhibit_d  = 1'b0;
      rsp_d      = rsp_reg_o;
      complete_d = 1'b0;
      timeout_d  = 1'b0;
      crc_d      = 1'b0;
      end_bit_d  = 1'b0;
      index_d    = 1'b0;
`ifdef SDHCI_CMD_CHECK_EN
      crc_en_d   = 1'b0;
      idx_en_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      cmd_o             <= 6'd0;
      cmd_arg_o         <= 32'd0;
      response_type_o   <= NO_RESPONSE;
      cmd_valid_o       <= 1'b0;
      cmd_inhibit_o     <= 1'b0;
      rsp_reg_o         <= '0;
      cmd_complete_o    <= 1'b0;
      cmd_timeout_err_o <= 1'b0;
      cmd_crc_err_o     <= 1'b0;
      cmd_end_bit_err_o <= 1'b0;
      cmd_index_err_o   <= 1'b0;
`ifdef SDHCI_CMD_CHECK_EN
      crc_en_q          <= 1'b0;
      idx_en_q          <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      cmd_o             <= cmd_d;
      cmd_arg_o         <= arg_d;
      response_type_o   <= rtype_d;
      cmd_valid_o       <= valid_d;
      cmd_inhibit_o     <= inhibit_d;
      rsp_reg_o         <= rsp_d;
      cmd_complete_o    <= complete_d;
      cmd_timeout_err_o <= timeout_d;
      cmd_crc_err_o     <= crc_d;
      cmd_end_bit_err_o <= end_bit_d;
      cmd_index_err_o   <= index_d;
`ifdef SDHCI_CMD_CHECK_EN
      crc_en_q          <= crc_en_d;
      idx_en_q          <= idx_en_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_issue_ctrl.sv
// Scoreboard bench for cmd_issue_ctrl; the bench acts as cmd_logic and predicts pulses/Response register.
module tb_cmd_issue_ctrl;
  import sdhci_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_ni, sw_rst_cmd_i, cmd_reg_wr_i;
  logic [5:0]     cmd_index_i;
  logic [31:0]    cmd_arg_i;
  logic [1:0]     rsp_type_sel_i;
  logic           crc_chk_en_i, idx_chk_en_i;
  logic           cmd_inhibit_o;
  logic [5:0]     cmd_o;
  logic [31:0]    cmd_arg_o;
  response_type_e response_type_o;
  logic           cmd_valid_o, cmd_ready_i, cmd_done_i, cmd_result_valid_i;
  logic [119:0]   rsp_i;
  logic           index_error_i, end_bit_error_i, crc_error_i, timeout_error_i;
  logic [127:0]   rsp_reg_o;
  logic           cmd_complete_o, cmd_timeout_err_o, cmd_crc_err_o, cmd_end_bit_err_o, cmd_index_err_o;

  cmd_issue_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sw_rst_cmd_i(sw_rst_cmd_i), .cmd_reg_wr_i(cmd_reg_wr_i),
    .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i), .rsp_type_sel_i(rsp_type_sel_i),
    .crc_chk_en_i(crc_chk_en_i), .idx_chk_en_i(idx_chk_en_i), .cmd_inhibit_o(cmd_inhibit_o),
    .cmd_o(cmd_o), .cmd_arg_o(cmd_arg_o), .response_type_o(response_type_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_done_i(cmd_done_i),
    .cmd_result_valid_i(cmd_result_valid_i), .rsp_i(rsp_i), .index_error_i(index_error_i),
    .end_bit_error_i(end_bit_error_i), .crc_error_i(crc_error_i), .timeout_error_i(timeout_error_i),
    .rsp_reg_o(rsp_reg_o), .cmd_complete_o(cmd_complete_o), .cmd_timeout_err_o(cmd_timeout_err_o),
    .cmd_crc_err_o(cmd_crc_err_o), .cmd_end_bit_err_o(cmd_end_bit_err_o),
    .cmd_index_err_o(cmd_index_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]   pulses;   // {complete, timeout, crc, end_bit, index}
    logic [127:0] rsp;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [127:0] rsp_model = '0;
  int           n_checks = 0;
  int           n_err = 0;
  logic [4:0]   pulses;

  assign pulses = {cmd_complete_o, cmd_timeout_err_o, cmd_crc_err_o, cmd_end_bit_err_o, cmd_index_err_o};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [1:0] exp_rtype(input logic [1:0] sel);
    case (sel)
      2'b00:   return 2'(NO_RESPONSE);
      2'b01:   return 2'(RESPONSE_136);
      2'b10:   return 2'(RESPONSE_48);
      default: return 2'(RESPONSE_48_BUSY);
    endcase
  endfunction

  // Monitor: every pulse set must match the oldest outstanding prediction
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && pulses != 5'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_pulse actual=%b required=none t=%0t", pulses, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulses", 128'(pulses), 128'(mon_e.pulses));
        chk("rsp_reg", rsp_reg_o, mon_e.rsp);
        chk("inhibit_at_pulse", 128'(cmd_inhibit_o), 128'(1'b0));
      end
    end
  end

  task automatic clear_rsp_inputs();
    cmd_done_i = 0; cmd_result_valid_i = 0; timeout_error_i = 0;
    crc_error_i = 0; end_bit_error_i = 0; index_error_i = 0; rsp_i = '0;
  endtask

  // kind: 0 result/done, 1 timeout, 2 result+timeout together, 3 sw reset then late result
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] sel,
                         input logic crc_en, input logic ien, input int rdy_dly, input int rsp_dly,
                         input int kind, input logic [2:0] errs, input logic [119:0] rsp,
                         input bit extra_wr, input bit fast);
    exp_t       e;
    logic [1:0] etype;
    logic       crc_rep, idx_rep;
    etype = exp_rtype(sel);
    if (!fast) @(negedge clk_i);
    cmd_reg_wr_i = 1; cmd_index_i = idx; cmd_arg_i = arg; rsp_type_sel_i = sel;
    crc_chk_en_i = crc_en; idx_chk_en_i = ien;
    @(negedge clk_i);
    cmd_reg_wr_i = 0; cmd_index_i = 6'($urandom); cmd_arg_i = $urandom;
    rsp_type_sel_i = 2'($urandom); crc_chk_en_i = 1'($urandom); idx_chk_en_i = 1'($urandom);
    chk("valid_rise", 128'(cmd_valid_o), 128'(1'b1));
    chk("inhibit_rise", 128'(cmd_inhibit_o), 128'(1'b1));
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk_i);
      chk("valid_hold", 128'(cmd_valid_o), 128'(1'b1));
    end
    chk("payload_idx", 128'(cmd_o), 128'(idx));
    chk("payload_arg", 128'(cmd_arg_o), 128'(arg));
    chk("payload_type", 128'(response_type_o), 128'(etype));
    cmd_ready_i = 1;
    @(negedge clk_i);
    cmd_ready_i = 0;
    chk("valid_fall", 128'(cmd_valid_o), 128'(1'b0));
    if (extra_wr) begin
      cmd_reg_wr_i = 1; cmd_index_i = ~idx; cmd_arg_i = ~arg;
      @(negedge clk_i);
      cmd_reg_wr_i = 0;
      chk("ignored_wr_idx", 128'(cmd_o), 128'(idx));
      chk("ignored_wr_valid", 128'(cmd_valid_o), 128'(1'b0));
    end
    if (sel != 2'b00) begin
      cmd_done_i = 1;
      @(negedge clk_i);
      cmd_done_i = 0;
    end
    repeat (rsp_dly) @(negedge clk_i);
    chk("inhibit_wait", 128'(cmd_inhibit_o), 128'(1'b1));

    if (kind == 3) begin
      sw_rst_cmd_i = 1;
      @(negedge clk_i);
      sw_rst_cmd_i = 0;
      chk("swrst_inhibit", 128'(cmd_inhibit_o), 128'(1'b0));
      chk("swrst_valid", 128'(cmd_valid_o), 128'(1'b0));
      chk("swrst_cmd", 128'(cmd_o), 128'(0));
      cmd_result_valid_i = 1; cmd_done_i = 1; rsp_i = rsp;
      {crc_error_i, end_bit_error_i, index_error_i} = errs;
      @(negedge clk_i);
      clear_rsp_inputs();
      chk("swrst_rsp_kept", rsp_reg_o, rsp_model);
      chk("swrst_inhibit_late", 128'(cmd_inhibit_o), 128'(1'b0));
    end else begin
`ifdef SDHCI_CMD_CHECK_EN
      crc_rep = errs[2] & crc_en;
      idx_rep = errs[0] & ien;
`else
      crc_rep = errs[2];
      idx_rep = errs[0];
`endif
      if (sel == 2'b00) begin
        e.pulses = 5'b10000;
        cmd_done_i = 1;
      end else if (kind == 0) begin
        e.pulses = {1'b1, 1'b0, crc_rep, errs[1], idx_rep};
        if (sel == 2'b01) rsp_model = {8'h00, rsp};
        else              rsp_model[31:0] = rsp[31:0];
        cmd_result_valid_i = 1; rsp_i = rsp;
        {crc_error_i, end_bit_error_i, index_error_i} = errs;
      end else begin
        e.pulses = 5'b01000;
        timeout_error_i = 1;
        if (kind == 2) begin
          cmd_result_valid_i = 1; rsp_i = rsp;
          {crc_error_i, end_bit_error_i, index_error_i} = errs;
        end
      end
      e.rsp = rsp_model;
      exp_q.push_back(e);
      @(negedge clk_i);
      clear_rsp_inputs();
      chk("inhibit_fall", 128'(cmd_inhibit_o), 128'(1'b0));
      chk("complete_latency", 128'(cmd_complete_o), 128'(e.pulses[4]));
    end
  endtask

  initial begin
    rst_ni = 0; sw_rst_cmd_i = 0; cmd_reg_wr_i = 0; cmd_index_i = 0; cmd_arg_i = 0;
    rsp_type_sel_i = 0; crc_chk_en_i = 0; idx_chk_en_i = 0; cmd_ready_i = 0;
    clear_rsp_inputs();
    repeat (3) @(negedge clk_i);
    chk("rst_valid", 128'(cmd_valid_o), 128'(1'b0));
    chk("rst_inhibit", 128'(cmd_inhibit_o), 128'(1'b0));
    chk("rst_pulses", 128'(pulses), 128'(0));
    chk("rst_cmd", 128'(cmd_o), 128'(0));
    chk("rst_arg", 128'(cmd_arg_o), 128'(0));
    chk("rst_rsp", rsp_reg_o, 128'(0));
    chk("rst_type", 128'(response_type_o), 128'(NO_RESPONSE));
    rst_ni = 1;

    // Directed scenarios
    run_cmd(6'd0, 32'h0, 2'b00, 0, 0, 0, 38, 0, 3'b000, '0, 0, 0);
    run_cmd(6'd2, 32'h0, 2'b01, 1, 1, 0, 2, 0, 3'b000, {60'hA5A5A5A5A5A5A5A, 60'h5A5A5A5A5A5A5A5}, 0, 0);
    run_cmd(6'd17, 32'h0000_1000, 2'b10, 1, 1, 0, 3, 0, 3'b000, 120'h0900, 0, 0);
    run_cmd(6'd13, 32'hDEAD_BEEF, 2'b10, 1, 1, 0, 4, 1, 3'b000, 120'h1234, 0, 0);
    run_cmd(6'd7, 32'h1111_2222, 2'b11, 0, 1, 10, 2, 0, 3'b000, 120'h77, 1, 0);
    run_cmd(6'd8, 32'h0000_01AA, 2'b10, 0, 0, 1, 1, 0, 3'b100, 120'h0000_ABCD, 0, 0);
    run_cmd(6'd9, 32'h0, 2'b10, 1, 0, 0, 1, 0, 3'b111, 120'hFACE, 0, 1);
    run_cmd(6'd55, 32'h5, 2'b01, 1, 1, 0, 2, 2, 3'b010, 120'hBAD, 0, 0);
    run_cmd(6'd18, 32'h6, 2'b10, 1, 1, 1, 3, 3, 3'b101, 120'h999, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [1:0]   sel;
      int           kind;
      logic [119:0] r;
      sel  = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 5);
      if (kind > 3) kind = 0;
      if (sel == 2'b00 && (kind == 1 || kind == 2)) kind = 0;
      r = 120'({$urandom, $urandom, $urandom, $urandom});
      run_cmd(6'($urandom), $urandom, sel, 1'($urandom), 1'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 5), kind, 3'($urandom), r,
              1'($urandom), 1'($urandom));
    end

    // Hard reset in the middle of a command
    @(negedge clk_i);
    cmd_reg_wr_i = 1; cmd_index_i = 6'd24; cmd_arg_i = 32'hCAFE; rsp_type_sel_i = 2'b01;
    @(negedge clk_i);
    cmd_reg_wr_i = 0; cmd_ready_i = 1;
    @(negedge clk_i);
    cmd_ready_i = 0; rst_ni = 0;
    @(negedge clk_i);
    rst_ni = 1;
    rsp_model = '0;
    chk("midrst_inhibit", 128'(cmd_inhibit_o), 128'(1'b0));
    chk("midrst_cmd", 128'(cmd_o), 128'(0));
    chk("midrst_rsp", rsp_reg_o, rsp_model);
    chk("midrst_type", 128'(response_type_o), 128'(NO_RESPONSE));
    cmd_result_valid_i = 1; rsp_i = 120'hFFFF;
    @(negedge clk_i);
    clear_rsp_inputs();
    @(negedge clk_i);
    chk("midrst_rsp_after", rsp_reg_o, rsp_model);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
